bram_word_packer: RTL

//   Write-side counterpart of the BRAM read/steer path: accepts the processed 8-bit pixel

---
 rtl/bram_word_packer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/bram_word_packer.sv
// Packs four accepted pixels per BRAM word (little-endian lanes) and writes one word per strobe.
// Optional macro PAD_FLUSH_EN adds In_Last to end a frame early with a PAD_VALUE-filled partial word.
module bram_word_packer #(
   parameter int                DATA_W    = 8,
   parameter int                WORD_W    = 32,
   parameter int                ADDR_W    = 9,
   parameter int                NUM_WORDS = 512,
   parameter logic [DATA_W-1:0] PAD_VALUE = '0
) (
   input  logic              CLK,
   input  logic              Reset_n,
   input  logic              Start,
   input  logic [DATA_W-1:0] In_Data,
   input  logic              In_Valid,
   output logic              In_Ready,
`ifdef PAD_FLUSH_EN
   input  logic              In_Last,
`endif
   output logic              Wr_En,
   output logic [ADDR_W-1:0] Wr_Addr,
   output logic [WORD_W-1:0] Wr_Data,
   output logic              Busy,
   output logic              Complete
);

   typedef enum logic [1:0] {IDLE, PACK, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

   state_t              state_q, state_d;
   logic [1:0]          lane_q, lane_d;
   logic [ADDR_W-1:0]   word_q, word_d;
   logic [WORD_W-1:0]   buf_q, buf_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [WORD_W-1:0]   wr_data_q, wr_data_d;
   logic                accept;
   logic                last_in;
   logic [WORD_W-1:0]   merged;

   // Drops the new byte into its lane; on a flush, lanes above it take the pad value.
   function automatic logic [WORD_W-1:0] merge_lane(input logic [WORD_W-1:0] w,
                                                    input logic [1:0]        lane,
                                                    input logic [DATA_W-1:0] d,
                                                    input logic              pad);
      logic [WORD_W-1:0] r;
      r = w;
      for (int i = 0; i < 4; i++) begin
         if (2'(i) == lane) r[i*DATA_W +: DATA_W] = d;
         else if (pad && (2'(i) > lane)) r[i*DATA_W +: DATA_W] = PAD_VALUE;
      end
      return r;
   endfunction

   assign accept   = In_Valid && (state_q == PACK);
`ifdef PAD_FLUSH_EN
   assign last_in  = In_Last;
`else
   assign last_in  = 1'b0;
`endif
   assign merged   = merge_lane(buf_q, lane_q, In_Data, last_in);

   assign In_Ready = (state_q == PACK);
   assign Busy     = (state_q == PACK);
   assign Complete = (state_q == DONE);
   assign Wr_En    = wr_en_q;
   assign Wr_Addr  = wr_addr_q;
   assign Wr_Data  = wr_data_q;

   always_comb begin
      state_d   = state_q;
      lane_d    = lane_q;
      word_d    = word_q;
      buf_d     = buf_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      case (state_q)
         IDLE, DONE: begin
            if (Start) begin
               state_d = PACK;
               lane_d  = '0;
               word_d  = '0;
               buf_d   = '0;
            end
         end
         PACK: begin
            if (accept) begin
               buf_d = merged;
               if ((lane_q == 2'd3) || last_in) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = word_q;
                  wr_data_d = merged;
                  lane_d    = '0;
                  word_d    = word_q + 1'b1;
                  // Final word (or early flush) ends the frame; no address wrap.
                  if ((word_q == LAST_WORD) || last_in) state_d = DONE;
               end else begin
                  lane_d = lane_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= IDLE;
         lane_q    <= '0;
         word_q    <= '0;
         buf_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         lane_q    <= lane_d;
         word_q    <= word_d;
         buf_q     <= buf_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

endmodule
